williams_blt_arbiter: RTL and testbench
=======================================

WILLIAMS_BLT_ARBITER -- requirements
Module: williams_blt_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_LATENCY, default 1, the clocks from mem_rd high to mem_rd_data valid (legal 1..3).
REQ-002 clk  in  1  12 MHz system clock; the block SHALL have one clock only.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 en_e_n  in  1  one-clock pulse every 12 clocks marking the E-cycle boundary.
REQ-005 halt  in  1  bus request from williams_sc1.
REQ-006 halt_ack  out  1  bus granted to williams_sc1.
REQ-007 blt_rd, blt_wr  in  1 each  blitter read and write request.
REQ-008 blt_address_out  in  16  blitter address.
REQ-009 blt_data_out  in  8  blitter write data.
REQ-010 blt_nibble_en  in  2  write enable per nibble: bit1 selects [7:4], bit0 selects [3:0].
REQ-011 blt_data_in  out  8  read data returned to the blitter.
REQ-012 blt_ack  out  1  one-clock access-complete pulse.
REQ-013 cpu_halt_n  out  1  6809 HALT, active-low.
REQ-014 cpu_ba  in  1  6809 bus-available flag, high when the CPU is halted.
REQ-015 mem_addr  out 16; mem_rd  out 1; mem_we  out 2 (per nibble); mem_wr_data  out 8; mem_rd_data  in 8.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, GRANT, RD, WR, RELEASE.
REQ-017 IDLE->REQ when halt=1; in REQ and every later non-IDLE state except RELEASE, cpu_halt_n SHALL be 0.
REQ-018 REQ->GRANT when cpu_ba=1 is sampled on a clock with en_e_n=1; halt_ack SHALL rise on the clock after that transition.
REQ-019 In GRANT, with en_e_n=1 and blt_rd or blt_wr high, the block SHALL latch address, data and nibble_en on that clock (cycle N).
REQ-020 Read: mem_rd SHALL be high for one clock at N+1; blt_data_in SHALL be registered and blt_ack pulsed at N+1+MEM_LATENCY; the FSM then returns to GRANT.
REQ-021 Write: mem_we and mem_wr_data SHALL be valid for one clock at N+1; blt_ack SHALL pulse at N+1 (behaviour with the macro in REQ-029).
REQ-022 If blt_rd and blt_wr are both high, the block SHALL treat the access as a write.
REQ-023 A write with blt_nibble_en=2'b00 SHALL still pulse blt_ack and SHALL drive mem_we=2'b00.
REQ-024 The block SHALL accept at most one access per E-cycle; requests not sampled with en_e_n=1 SHALL be ignored.
REQ-025 If halt falls in GRANT, the FSM SHALL go to RELEASE; if halt falls during RD or WR, the access SHALL complete and blt_ack SHALL be suppressed before entering RELEASE.
REQ-026 RELEASE SHALL last one clock with halt_ack=0 and cpu_halt_n=1, then go to IDLE.
REQ-027 If halt falls in REQ, the FSM SHALL go to RELEASE.

Reset
REQ-028 While rst_n=0 at a clock edge, the block SHALL enter IDLE and drive cpu_halt_n=1, halt_ack=0, blt_ack=0, mem_rd=0, mem_we=0, mem_addr=0, mem_wr_data=0 and blt_data_in=0, aborting any in-flight access without write.

Configuration
REQ-029 With WILLIAMS_BLT_RMW_EN defined, a write with nibble_en of 2'b01 or 2'b10 SHALL be done as read-merge-write: mem_rd at N+1, then mem_we=2'b11 with merged data at N+2+MEM_LATENCY, with blt_ack pulsed in that same clock.
REQ-030 Without WILLIAMS_BLT_RMW_EN, mem_we SHALL equal the latched nibble_en and no read SHALL be issued for a write.

Structure
REQ-031 A shared package williams_pkg SHALL hold the FSM state enum and the constant E_CYCLE_CLKS=12.
REQ-032 A sub-module williams_nibble_merge (combinational merge of old data, new data and nibble_en) SHALL be used only under WILLIAMS_BLT_RMW_EN.

Verification
REQ-033 Handshake: halt=1, then cpu_ba=1 before the next en_e_n -> cpu_halt_n=0 within 1 clock; halt_ack=1 one clock after the en_e_n sample.
REQ-034 Read: addr 16'h9800, mem_rd_data 8'hA5, MEM_LATENCY=1 -> mem_rd at N+1, blt_data_in=8'hA5 and blt_ack at N+2.
REQ-035 Write: data 8'h3C, nibble_en 2'b11 -> mem_we=2'b11 and mem_wr_data=8'h3C at N+1, blt_ack at N+1.
REQ-036 Write with WILLIAMS_BLT_RMW_EN: old 8'hF5, new 8'h3C, nibble_en 2'b10 -> mem_we=2'b11 with data 8'h35 at N+3.
REQ-037 halt drops during RD -> read completes, no blt_ack, one RELEASE clock, then cpu_halt_n=1 and IDLE.
REQ-038 rst_n=0 during WR -> no write; all outputs at their REQ-028 values on the next clock.

Source files
------------

// File: rtl/williams_pkg.sv
// Shared definitions for the Williams blitter bus arbiter: FSM state encoding
// and E-cycle timing constant.
package williams_pkg;

  localparam int E_CYCLE_CLKS = 12;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_GRANT   = 3'd2,
    ST_RD      = 3'd3,
    ST_WR      = 3'd4,
    ST_RELEASE = 3'd5
  } state_t;

endpackage

// File: rtl/williams_nibble_merge.sv
// Combinational nibble merge: each nibble comes from new data when its enable
// bit is set, otherwise from the old memory contents.
module williams_nibble_merge (
  input  logic [7:0] i_old,
  input  logic [7:0] i_new,
  input  logic [1:0] i_nibble_en,
  output logic [7:0] o_merged
);

  assign o_merged[7:4] = i_nibble_en[1] ? i_new[7:4] : i_old[7:4];
  assign o_merged[3:0] = i_nibble_en[0] ? i_new[3:0] : i_old[3:0];

endmodule

// File: rtl/williams_blt_arbiter.sv
// Arbitrates the memory bus between the 6809 and the blitter, one access per E-cycle.
// Define WILLIAMS_BLT_RMW_EN to turn single-nibble writes into read-merge-write.
module williams_blt_arbiter
  import williams_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_e_n,
  input  logic        halt,
  output logic        halt_ack,
  input  logic        blt_rd,
  input  logic        blt_wr,
  input  logic [15:0] blt_address_out,
  input  logic [7:0]  blt_data_out,
  input  logic [1:0]  blt_nibble_en,
  output logic [7:0]  blt_data_in,
  output logic        blt_ack,
  output logic        cpu_halt_n,
  input  logic        cpu_ba,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [1:0]  mem_we,
  output logic [7:0]  mem_wr_data,
  input  logic [7:0]  mem_rd_data,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] LAT    = 3'(MEM_LATENCY);
  localparam logic [2:0] LAT_P1 = 3'(MEM_LATENCY + 1);

  state_t      r_state, w_next;
  logic [2:0]  r_cnt;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [1:0]  r_nib;
  logic        r_halt_ack, r_blt_ack, r_mem_rd, r_abort;
  logic [1:0]  r_mem_we;
  logic [7:0]  r_mem_wr_data, r_blt_data_in;

  logic        w_latch, w_mem_rd, w_wr_strobe, w_rd_capture, w_done;
  logic        w_ack, w_halt_ack, w_busy_next, w_abort;
  logic [1:0]  w_mem_we;
  logic [7:0]  w_wr_data;

`ifdef WILLIAMS_BLT_RMW_EN
  logic       w_rmw, w_old_capture;
  logic [7:0] r_old, w_merged;

  assign w_rmw = (r_nib == 2'b01) || (r_nib == 2'b10);

  williams_nibble_merge u_merge (
    .i_old       (r_old),
    .i_new       (r_wdata),
    .i_nibble_en (r_nib),
    .o_merged    (w_merged)
  );

  assign w_wr_data = w_rmw ? w_merged : r_wdata;
`else
  assign w_wr_data = r_wdata;
`endif

  // r_cnt counts clocks since the latch edge; edge N+1+k sees r_cnt == k.
  always_comb begin
    w_next       = r_state;
    w_latch      = 1'b0;
    w_mem_rd     = 1'b0;
    w_mem_we     = 2'b00;
    w_wr_strobe  = 1'b0;
    w_rd_capture = 1'b0;
    w_done       = 1'b0;
`ifdef WILLIAMS_BLT_RMW_EN
    w_old_capture = 1'b0;
`endif
    case (r_state)
      ST_IDLE: if (halt) w_next = ST_REQ;
      ST_REQ: begin
        if (!halt)                 w_next = ST_RELEASE;
        else if (cpu_ba && en_e_n) w_next = ST_GRANT;
      end
      ST_GRANT: begin
        if (!halt) begin
          w_next = ST_RELEASE;
        end else if (en_e_n && blt_wr) begin
          w_next  = ST_WR;
          w_latch = 1'b1;
        end else if (en_e_n && blt_rd) begin
          w_next  = ST_RD;
          w_latch = 1'b1;
        end
      end
      ST_RD: begin
        if (r_cnt == 3'd0) w_mem_rd = 1'b1;
        if (r_cnt == LAT) begin
          w_rd_capture = 1'b1;
          w_done       = 1'b1;
        end
      end
      ST_WR: begin
`ifdef WILLIAMS_BLT_RMW_EN
        if (w_rmw) begin
          if (r_cnt == 3'd0) w_mem_rd = 1'b1;
          if (r_cnt == LAT)  w_old_capture = 1'b1;
          if (r_cnt == LAT_P1) begin
            w_mem_we    = 2'b11;
            w_wr_strobe = 1'b1;
            w_done      = 1'b1;
          end
        end else begin
          w_mem_we    = r_nib;
          w_wr_strobe = 1'b1;
          w_done      = 1'b1;
        end
`else
        w_mem_we    = r_nib;
        w_wr_strobe = 1'b1;
        w_done      = 1'b1;
`endif
      end
      ST_RELEASE: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
    if (w_done) w_next = (halt && !r_abort) ? ST_GRANT : ST_RELEASE;
  end

  // An access whose halt dropped at any point finishes silently, then releases.
  assign w_ack       = w_done && halt && !r_abort;
  assign w_busy_next = (w_next == ST_RD) || (w_next == ST_WR);
  assign w_abort     = w_busy_next && ((r_state == ST_RD) || (r_state == ST_WR)) &&
                       (r_abort || !halt);
  assign w_halt_ack  = (w_busy_next || (w_next == ST_GRANT)) && (r_state != ST_REQ);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 3'd0;
      r_addr        <= 16'h0000;
      r_wdata       <= 8'h00;
      r_nib         <= 2'b00;
      r_halt_ack    <= 1'b0;
      r_blt_ack     <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_abort       <= 1'b0;
      r_mem_we      <= 2'b00;
      r_mem_wr_data <= 8'h00;
      r_blt_data_in <= 8'h00;
`ifdef WILLIAMS_BLT_RMW_EN
      r_old         <= 8'h00;
`endif
    end else begin
      r_state    <= w_next;
      r_cnt      <= (w_busy_next && (w_next == r_state)) ? r_cnt + 3'd1 : 3'd0;
      r_halt_ack <= w_halt_ack;
      r_blt_ack  <= w_ack;
      r_mem_rd   <= w_mem_rd;
      r_mem_we   <= w_mem_we;
      r_abort    <= w_abort;
      if (w_latch) begin
        r_addr  <= blt_address_out;
        r_wdata <= blt_data_out;
        r_nib   <= blt_nibble_en;
      end
      if (w_wr_strobe)  r_mem_wr_data <= w_wr_data;
      if (w_rd_capture) r_blt_data_in <= mem_rd_data;
`ifdef WILLIAMS_BLT_RMW_EN
      if (w_old_capture) r_old <= mem_rd_data;
`endif
    end
  end

  assign cpu_halt_n  = !((r_state == ST_REQ) || (r_state == ST_GRANT) ||
                         (r_state == ST_RD)  || (r_state == ST_WR));
  assign halt_ack    = r_halt_ack;
  assign blt_ack     = r_blt_ack;
  assign blt_data_in = r_blt_data_in;
  assign mem_addr    = r_addr;
  assign mem_rd      = r_mem_rd;
  assign mem_we      = r_mem_we;
  assign mem_wr_data = r_mem_wr_data;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_williams_blt_arbiter.sv
// Scoreboard bench for williams_blt_arbiter: directed accesses push timed expected
// bus events; a negedge monitor pops and compares every event the DUT presents.
module tb_williams_blt_arbiter;
  import williams_pkg::*;

  localparam int LAT = 1;
  localparam int W   = 52;

  logic        clk = 1'b0;
  logic        rst_n, en_e_n, halt, blt_rd, blt_wr, cpu_ba;
  logic [15:0] blt_address_out;
  logic [7:0]  blt_data_out;
  logic [1:0]  blt_nibble_en;
  logic        halt_ack, blt_ack, cpu_halt_n, mem_rd;
  logic [7:0]  blt_data_in, mem_wr_data;
  logic [7:0]  mem_rd_data = 8'h00;
  logic [15:0] mem_addr;
  logic [1:0]  mem_we;
  logic [2:0]  dbg_state;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  last_rd = 8'h00;
  logic [7:0]  mem_arr [256];
  logic [2:0]  rd_pipe = 3'b000;
  logic [W-1:0] exp_q[$];

  williams_blt_arbiter #(.MEM_LATENCY(LAT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_e_n          (en_e_n),
    .halt            (halt),
    .halt_ack        (halt_ack),
    .blt_rd          (blt_rd),
    .blt_wr          (blt_wr),
    .blt_address_out (blt_address_out),
    .blt_data_out    (blt_data_out),
    .blt_nibble_en   (blt_nibble_en),
    .blt_data_in     (blt_data_in),
    .blt_ack         (blt_ack),
    .cpu_halt_n      (cpu_halt_n),
    .cpu_ba          (cpu_ba),
    .mem_addr        (mem_addr),
    .mem_rd          (mem_rd),
    .mem_we          (mem_we),
    .mem_wr_data     (mem_wr_data),
    .mem_rd_data     (mem_rd_data),
    .dbg_state       (dbg_state)
  );

  // Clock and cycle index: at a negedge, cyc is the index of the last posedge.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: data appears LAT-1 negedges after mem_rd is seen, sampled on the next posedge.
  always @(negedge clk) begin
    rd_pipe = {rd_pipe[1:0], mem_rd};
    if (rd_pipe[LAT-1]) mem_rd_data = mem_arr[mem_addr[7:0]];
    else                mem_rd_data = 8'h00;
  end

  // Event word: {cycle, ack, rd, we, addr, written byte, returned byte}
  function automatic logic [W-1:0] ev(input int c, input logic ack, input logic rd,
                                      input logic [1:0] we, input logic [15:0] a,
                                      input logic [7:0] wd, input logic [7:0] rdv);
    return {16'(c), ack, rd, we, a, wd, rdv};
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] obs, exp_w;
    while (exp_q.size() > 0 && exp_q[0][W-1:W-16] < 16'(cyc)) begin
      exp_w = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event cycle %0d: got nothing, expected %h", cyc, exp_w);
    end
    if (blt_ack || mem_rd || (mem_we != 2'b00)) begin
      obs = ev(cyc, blt_ack, mem_rd, mem_we, mem_addr,
               (mem_we != 2'b00) ? mem_wr_data : 8'h00, blt_ack ? blt_data_in : 8'h00);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cycle %0d: got %h, expected none", cyc, obs);
      end else begin
        exp_w = exp_q.pop_front();
        if (obs !== exp_w) begin
          errors++;
          $display("FAIL bus_event cycle %0d: got %h, expected %h", cyc, obs, exp_w);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, got, exp_v);
    end
  endtask

  task automatic e_wait();
    repeat (E_CYCLE_CLKS - 1) @(negedge clk);
  endtask

  // Drive one request on an en_e_n clock; exp_d is the hand-computed byte
  // written to memory (write) or returned to the blitter (read).
  task automatic issue(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [7:0] d, input logic [1:0] nib,
                       input logic ack_ok, input logic push_en, input logic [7:0] exp_d);
    int n;
    n = cyc + 1;
    blt_rd = rd; blt_wr = wr; blt_address_out = a; blt_data_out = d;
    blt_nibble_en = nib; en_e_n = 1'b1;
    if (push_en) begin
      if (wr) begin
`ifdef WILLIAMS_BLT_RMW_EN
        if (nib == 2'b01 || nib == 2'b10) begin
          exp_q.push_back(ev(n + 1, 1'b0, 1'b1, 2'b00, a, 8'h00, 8'h00));
          exp_q.push_back(ev(n + 2 + LAT, ack_ok, 1'b0, 2'b11, a, exp_d,
                             ack_ok ? last_rd : 8'h00));
        end else
`endif
        if (ack_ok || nib != 2'b00)
          exp_q.push_back(ev(n + 1, ack_ok, 1'b0, nib, a, (nib != 2'b00) ? exp_d : 8'h00,
                             ack_ok ? last_rd : 8'h00));
      end else if (rd) begin
        exp_q.push_back(ev(n + 1, 1'b0, 1'b1, 2'b00, a, 8'h00, 8'h00));
        if (ack_ok) exp_q.push_back(ev(n + 1 + LAT, 1'b1, 1'b0, 2'b00, a, 8'h00, exp_d));
        last_rd = exp_d;
      end
    end
    @(negedge clk);
    en_e_n = 1'b0; blt_rd = 1'b0; blt_wr = 1'b0;
  endtask

  task automatic acquire();
    halt = 1'b1;
    @(negedge clk);
    check("req_cpu_halt_n", 32'(cpu_halt_n), 32'd0);
    check("req_state", 32'(dbg_state), 32'(ST_REQ));
    check("req_halt_ack", 32'(halt_ack), 32'd0);
    cpu_ba = 1'b1; en_e_n = 1'b1;
    @(negedge clk);
    en_e_n = 1'b0;
    check("grant_state", 32'(dbg_state), 32'(ST_GRANT));
    check("grant_halt_ack_early", 32'(halt_ack), 32'd0);
    @(negedge clk);
    check("grant_halt_ack", 32'(halt_ack), 32'd1);
    repeat (E_CYCLE_CLKS - 2) @(negedge clk);
  endtask

  task automatic check_released();
    check("release_state", 32'(dbg_state), 32'(ST_RELEASE));
    check("release_cpu_halt_n", 32'(cpu_halt_n), 32'd1);
    check("release_halt_ack", 32'(halt_ack), 32'd0);
    @(negedge clk);
    check("idle_state", 32'(dbg_state), 32'(ST_IDLE));
    check("idle_cpu_halt_n", 32'(cpu_halt_n), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    check({tag, "_cpu_halt_n"}, 32'(cpu_halt_n), 32'd1);
    check({tag, "_halt_ack"}, 32'(halt_ack), 32'd0);
    check({tag, "_blt_ack"}, 32'(blt_ack), 32'd0);
    check({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wr_data"}, 32'(mem_wr_data), 32'd0);
    check({tag, "_blt_data_in"}, 32'(blt_data_in), 32'd0);
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'(i);
    rst_n = 1'b0; en_e_n = 1'b0; halt = 1'b0; cpu_ba = 1'b0;
    blt_rd = 1'b0; blt_wr = 1'b0; blt_address_out = 16'h0000;
    blt_data_out = 8'h00; blt_nibble_en = 2'b00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Requests while idle are ignored.
    blt_rd = 1'b1; en_e_n = 1'b1;
    @(negedge clk);
    blt_rd = 1'b0; en_e_n = 1'b0;
    check("idle_ignores_req", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);

    acquire();

    mem_arr[8'h00] = 8'hA5;
    issue(1'b1, 1'b0, 16'h9800, 8'h00, 2'b00, 1'b1, 1'b1, 8'hA5);
    e_wait();
    check("after_read_state", 32'(dbg_state), 32'(ST_GRANT));
    issue(1'b0, 1'b1, 16'h1234, 8'h3C, 2'b11, 1'b1, 1'b1, 8'h3C);
    e_wait();
    issue(1'b0, 1'b1, 16'h1235, 8'h77, 2'b00, 1'b1, 1'b1, 8'h00);
    e_wait();
    issue(1'b1, 1'b1, 16'h2000, 8'h5A, 2'b11, 1'b1, 1'b1, 8'h5A);
    e_wait();

    // Requests without en_e_n must not start an access.
    blt_wr = 1'b1; blt_nibble_en = 2'b11; blt_data_out = 8'hEE;
    repeat (3) @(negedge clk);
    blt_wr = 1'b0;
    check("no_en_stays_grant", 32'(dbg_state), 32'(ST_GRANT));
    repeat (8) @(negedge clk);

    mem_arr[8'h40] = 8'hF5;
`ifdef WILLIAMS_BLT_RMW_EN
    issue(1'b0, 1'b1, 16'h4040, 8'h3C, 2'b10, 1'b1, 1'b1, 8'h35);
`else
    issue(1'b0, 1'b1, 16'h4040, 8'h3C, 2'b10, 1'b1, 1'b1, 8'h3C);
`endif
    e_wait();
    mem_arr[8'h41] = 8'hF5;
`ifdef WILLIAMS_BLT_RMW_EN
    issue(1'b0, 1'b1, 16'h4041, 8'h3C, 2'b01, 1'b1, 1'b1, 8'hFC);
`else
    issue(1'b0, 1'b1, 16'h4041, 8'h3C, 2'b01, 1'b1, 1'b1, 8'h3C);
`endif
    e_wait();
    mem_arr[8'hFF] = 8'h5C;
    issue(1'b1, 1'b0, 16'h00FF, 8'h00, 2'b00, 1'b1, 1'b1, 8'h5C);
    e_wait();

    // halt drops during a read: read completes, no ack, one RELEASE clock.
    mem_arr[8'h10] = 8'h99;
    issue(1'b1, 1'b0, 16'h8010, 8'h00, 2'b00, 1'b0, 1'b1, 8'h99);
    halt = 1'b0; cpu_ba = 1'b0;
    repeat (2) @(negedge clk);
    check_released();
    @(negedge clk);

    // halt drops during a write: write happens, ack suppressed.
    acquire();
    issue(1'b0, 1'b1, 16'h3000, 8'hC3, 2'b11, 1'b0, 1'b1, 8'hC3);
    halt = 1'b0; cpu_ba = 1'b0;
    @(negedge clk);
    check_released();
    @(negedge clk);

    // halt drops in GRANT, then in REQ.
    acquire();
    halt = 1'b0; cpu_ba = 1'b0;
    @(negedge clk);
    check_released();
    halt = 1'b1;
    @(negedge clk);
    check("req_again_state", 32'(dbg_state), 32'(ST_REQ));
    halt = 1'b0;
    @(negedge clk);
    check_released();
    @(negedge clk);

    // Reset in WR aborts the write.
    acquire();
    issue(1'b0, 1'b1, 16'h5555, 8'hEE, 2'b11, 1'b1, 1'b0, 8'hEE);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("wr_reset");
    last_rd = 8'h00;
    rst_n = 1'b1; halt = 1'b0; cpu_ba = 1'b0;
    repeat (6) @(negedge clk);

    while (exp_q.size() > 0) begin
      logic [W-1:0] left;
      left = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL leftover_event: got nothing, expected %h", left);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
